// File: rtl/reg_wb_writer_pkg.sv
// Shared types and sizing for the register-file writeback controller.
//   WB_DEPTH      default writeback queue depth
//   REGADDR_WIDTH register address width
//   WORD_WIDTH    register data width
//   wb_state_t    write-strobe sequencer states
package reg_wb_writer_pkg;

    localparam int unsigned WB_DEPTH      = 4;
    localparam int unsigned REGADDR_WIDTH = 5;
    localparam int unsigned WORD_WIDTH    = 32;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_SETUP  = 2'd1,
        WB_STROBE = 2'd2
    } wb_state_t;

    // The output registers hold a live write whenever the sequencer is not idle.
    function automatic logic wb_in_flight(input wb_state_t st);
        return st != WB_IDLE;
    endfunction

endpackage

// File: rtl/reg_wb_writer_wb_fifo.sv
// Writeback request queue with every slot exposed for operand bypass and
// pending-register search.
//   clk, rst               clock, synchronous active-low reset
//   push, push_addr/data   enqueue (ignored when full)
//   pop                    dequeue head (ignored when empty)
//   head_addr/data         oldest entry
//   count, rd_ptr          occupancy and head slot index
//   full, empty            occupancy flags
//   entry_addr/data        raw slot contents, indexed by slot
module wb_fifo
    import reg_wb_writer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned AW    = REGADDR_WIDTH,
    parameter int unsigned DW    = WORD_WIDTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic [PW-1:0] rd_ptr,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] entry_addr [DEPTH],
    output logic [DW-1:0] entry_data [DEPTH]
);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign entry_addr = addr_mem;
    assign entry_data = data_mem;

    // Storage is not reset; validity comes from count/rd_ptr only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_wb_writer.sv
// Write-side controller for the register file. Queues writeback requests,
// replays them onto the regfile write port as a setup-then-strobe sequence,
// bypasses queued/in-flight values to the read ports and reports which
// registers have writes outstanding.
//   clk, rst                      clock, synchronous active-low reset
//   wb_valid/wb_ready             writeback request handshake
//   wb_addr, wb_data              writeback destination and value
//   rd_addr1/2, rf_data1/2        read port addresses and raw regfile data
//   rd_data1/2                    bypassed operands
//   reg_write/reg_waddr/reg_wdata registered regfile write port
//   pending                       per-register outstanding-write flags
//   idle                          nothing queued and sequencer idle
module reg_wb_writer
    import reg_wb_writer_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned AW    = REGADDR_WIDTH,
    parameter int unsigned DW    = WORD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [AW-1:0]      wb_addr,
    input  logic [DW-1:0]      wb_data,
    input  logic [AW-1:0]      rd_addr1,
    input  logic [AW-1:0]      rd_addr2,
    input  logic [DW-1:0]      rf_data1,
    input  logic [DW-1:0]      rf_data2,
    output logic [DW-1:0]      rd_data1,
    output logic [DW-1:0]      rd_data2,
    output logic               reg_write,
    output logic [AW-1:0]      reg_waddr,
    output logic [DW-1:0]      reg_wdata,
    output logic [(2**AW)-1:0] pending,
    output logic               idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_state_t     state;
    logic          push;
    logic          pop;
    logic          in_flight;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] entry_addr [DEPTH];
    logic [DW-1:0] entry_data [DEPTH];

    // Writes to $zero complete the handshake but never enter the queue.
    assign wb_ready  = !fifo_full;
    assign push      = wb_valid && wb_ready && (wb_addr != '0);
    assign pop       = !fifo_empty && ((state == WB_IDLE) || (state == WB_STROBE));
    assign in_flight = wb_in_flight(state);
    assign idle      = fifo_empty && (state == WB_IDLE);

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (wb_addr),
        .push_data  (wb_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entry_addr (entry_addr),
        .entry_data (entry_data)
    );

    // Write sequencer: address/data settle for a full cycle before the
    // strobe, and the strobe always drops between writes because the regfile
    // is level-sensitive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WB_IDLE;
            reg_write <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    reg_write <= 1'b0;
                    if (!fifo_empty) begin
                        reg_waddr <= head_addr;
                        reg_wdata <= head_data;
                        state     <= WB_SETUP;
                    end
                end
                WB_SETUP: begin
                    reg_write <= 1'b1;
                    state     <= WB_STROBE;
                end
                WB_STROBE: begin
                    reg_write <= 1'b0;
                    if (!fifo_empty) begin
                        reg_waddr <= head_addr;
                        reg_wdata <= head_data;
                        state     <= WB_SETUP;
                    end else begin
                        state <= WB_IDLE;
                    end
                end
                default: begin
                    reg_write <= 1'b0;
                    state     <= WB_IDLE;
                end
            endcase
        end
    end

    // Operand bypass: scan oldest to youngest so the youngest match wins,
    // then fall back to the in-flight write, then to the regfile.
    always_comb begin
        logic          hit1;
        logic          hit2;
        logic [DW-1:0] qval1;
        logic [DW-1:0] qval2;
        logic [PW-1:0] idx;
        hit1  = 1'b0;
        hit2  = 1'b0;
        qval1 = '0;
        qval2 = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (entry_addr[idx] == rd_addr1) begin
                    hit1  = 1'b1;
                    qval1 = entry_data[idx];
                end
                if (entry_addr[idx] == rd_addr2) begin
                    hit2  = 1'b1;
                    qval2 = entry_data[idx];
                end
            end
        end

        if (rd_addr1 == '0)                          rd_data1 = '0;
        else if (hit1)                               rd_data1 = qval1;
        else if (in_flight && reg_waddr == rd_addr1) rd_data1 = reg_wdata;
        else                                         rd_data1 = rf_data1;

        if (rd_addr2 == '0)                          rd_data2 = '0;
        else if (hit2)                               rd_data2 = qval2;
        else if (in_flight && reg_waddr == rd_addr2) rd_data2 = reg_wdata;
        else                                         rd_data2 = rf_data2;
    end

    // Pending scoreboard decoded from registered queue and sequencer state.
    always_comb begin
        logic [PW-1:0] idx;
        pending = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) pending[entry_addr[idx]] = 1'b1;
        end
        if (in_flight) pending[reg_waddr] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_reg_wb_writer.sv
// Self-checking bench for reg_wb_writer: cycle model plus write scoreboard.
module tb_reg_wb_writer;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    localparam int M_IDLE   = 0;
    localparam int M_SETUP  = 1;
    localparam int M_STROBE = 2;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        reg_write;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [31:0] pending;
    logic        idle;

    reg_wb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .reg_write (reg_write),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .pending   (pending),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state.
    ent_t        mq[$];
    ent_t        exp_q[$];
    int          m_state = M_IDLE;
    logic        m_rw = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic        prev_rw = 1'b0;
    logic        saw_full = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        ent_t e;
        bit   acc;
        bit   do_pop;
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            m_state = M_IDLE;
            m_rw    = 1'b0;
            m_wa    = '0;
            m_wd    = '0;
        end else begin
            acc    = wb_valid && (mq.size() != 4);
            do_pop = (m_state != M_SETUP) && (mq.size() != 0);
            case (m_state)
                M_SETUP: begin
                    m_rw    = 1'b1;
                    m_state = M_STROBE;
                end
                default: begin
                    m_rw = 1'b0;
                    if (do_pop) begin
                        e       = mq.pop_front();
                        m_wa    = e.a;
                        m_wd    = e.d;
                        m_state = M_SETUP;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            endcase
            if (acc && wb_addr != 5'd0) begin
                e.a = wb_addr;
                e.d = wb_data;
                mq.push_back(e);
                exp_q.push_back(e);
            end
        end
    end

    function automatic logic [31:0] m_bypass(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == a) return mq[i].d;
        if (m_state != M_IDLE && m_wa == a) return m_wd;
        return rf;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_state != M_IDLE) p[m_wa] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic check_all();
        ent_t e;
        check("wb_ready", 64'(wb_ready), 64'(mq.size() != 4));
        check("idle", 64'(idle), 64'(mq.size() == 0 && m_state == M_IDLE));
        check("reg_write", 64'(reg_write), 64'(m_rw));
        check("reg_waddr", 64'(reg_waddr), 64'(m_wa));
        check("reg_wdata", 64'(reg_wdata), 64'(m_wd));
        check("pending", 64'(pending), 64'(m_pending()));
        check("rd_data1", 64'(rd_data1), 64'(m_bypass(rd_addr1, rf_data1)));
        check("rd_data2", 64'(rd_data2), 64'(m_bypass(rd_addr2, rf_data2)));
        check("strobe_gap", 64'(reg_write & prev_rw), 64'(0));
        if (reg_write) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 64'(reg_waddr), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", 64'(reg_waddr), 64'(e.a));
                check("sb_data", 64'(reg_wdata), 64'(e.d));
            end
        end
        if (!wb_ready) saw_full = 1'b1;
        prev_rw = reg_write;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        int n;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        n = 0;
        while (!wb_ready && n < 50) begin
            tick();
            n++;
        end
        if (!wb_ready) check("push_timeout", 64'(wb_ready), 64'(1));
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!idle && n < 300) begin
            tick();
            n++;
        end
        check("drain_idle", 64'(idle), 64'(1));
    endtask

    initial begin
        rst      = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rf_data1 = '0;
        rf_data2 = '0;
        @(negedge clk);

        // Reset held with random inputs.
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_addr  = 5'($urandom_range(0, 31));
            wb_data  = $urandom;
            tick();
        end
        check("rst_reg_write", 64'(reg_write), 64'(0));
        check("rst_reg_waddr", 64'(reg_waddr), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_wb_ready", 64'(wb_ready), 64'(1));
        check("rst_idle", 64'(idle), 64'(1));
        rst      = 1'b1;
        wb_valid = 1'b0;
        tick();

        // Single write latency.
        rd_addr2 = 5'd5;
        rf_data2 = 32'h1234_5678;
        push(5'd5, 32'hDEAD_BEEF);
        check("single_pending_q", 64'(pending[5]), 64'(1));
        check("single_bypass_q", 64'(rd_data2), 64'(32'hDEAD_BEEF));
        tick();
        check("single_setup_addr", 64'(reg_waddr), 64'(5));
        check("single_setup_wr", 64'(reg_write), 64'(0));
        tick();
        check("single_strobe_wr", 64'(reg_write), 64'(1));
        check("single_strobe_pend", 64'(pending[5]), 64'(1));
        tick();
        check("single_done_pend", 64'(pending[5]), 64'(0));
        check("single_done_rd", 64'(rd_data2), 64'(32'h1234_5678));
        drain();

        // Fill queue back-to-back; enough requests to hit full.
        saw_full = 1'b0;
        for (int i = 1; i <= 10; i++) push(5'(i), 32'(i) * 32'h0101_1111);
        check("fill_saw_full", 64'(saw_full), 64'(1));
        drain();

        // Youngest-entry bypass.
        rd_addr1 = 5'd7;
        rf_data1 = 32'd0;
        push(5'd7, 32'd1);
        push(5'd7, 32'd2);
        check("bypass_youngest", 64'(rd_data1), 64'(2));
        drain();
        rf_data1 = 32'h0000_0055;
        #1;
        check("bypass_after_drain", 64'(rd_data1), 64'(32'h55));

        // Writes to register zero are dropped.
        rd_addr1 = 5'd0;
        rf_data1 = 32'hCAFE_F00D;
        push(5'd0, 32'hFFFF_FFFF);
        check("zero_idle", 64'(idle), 64'(1));
        check("zero_rd", 64'(rd_data1), 64'(0));
        for (int i = 0; i < 3; i++) tick();
        check("zero_no_write", 64'(reg_write), 64'(0));

        // Reset while a write is set up with three more queued.
        for (int i = 0; i < 20; i++) begin
            push(5'(10 + i), $urandom);
            if (m_state == M_SETUP && mq.size() == 3) break;
        end
        check("midrst_reached", 64'(mq.size()), 64'(3));
        rst = 1'b0;
        tick();
        check("midrst_reg_write", 64'(reg_write), 64'(0));
        check("midrst_pending", 64'(pending), 64'(0));
        check("midrst_idle", 64'(idle), 64'(1));
        rst = 1'b1;
        tick();
        push(5'd9, 32'hA5A5_0009);
        drain();

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            rd_addr1 = 5'($urandom_range(0, 7));
            rd_addr2 = 5'($urandom_range(0, 7));
            rf_data1 = $urandom;
            rf_data2 = $urandom;
            tick();
        end
        wb_valid = 1'b0;
        drain();
        check("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
